// File: rtl/score_board.sv
// score_board: apple score, play time, session high score, display words.
// Ports: clk/rst_n, add_cube, game_status in; score, high_score, play_time, new_record, data, point out.
module score_board #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int DISP_SEC = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        add_cube,
  input  logic [1:0]  game_status,
  output logic [7:0]  score,
  output logic [7:0]  high_score,
  output logic [9:0]  play_time,
  output logic        new_record,
  output logic [19:0] data,
  output logic [5:0]  point
);

  localparam int PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam int DW = (DISP_SEC > 1) ? $clog2(DISP_SEC) : 1;
  localparam logic [PW-1:0] PMAX = PW'(CLK_FREQ - 1);
  localparam logic [DW-1:0] DMAX = DW'(DISP_SEC - 1);
  localparam logic [9:0] TMAX = 10'd999;
  localparam logic [7:0] SMAX = 8'd255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [DW-1:0] dsec_q, dsec_d;
  logic          show_q, show_d;
  logic [7:0]    score_q, score_d;
  logic [7:0]    hs_q, hs_d;
  logic [9:0]    pt_q, pt_d;
  logic          nr_q, nr_d;
  logic [19:0]   data_q, data_d;
  logic [5:0]    point_q, point_d;

  logic          entry;
  logic          to_play;
  logic          play_end;
  logic          stay_play;
  logic          stay_over;
  logic          sec_tick;
  logic [19:0]   t20;
  logic [19:0]   t_x1000;

  // Game core owns the mode; we just follow it.
  always_comb begin
    state_d = OVER;
    unique case (1'b1)
      (game_status == 2'b01): state_d = IDLE;
      (game_status == 2'b10): state_d = PLAY;
      default:                state_d = OVER;
    endcase
  end

  assign entry     = (state_d != state_q);
  assign to_play   = entry && (state_d == PLAY);
  assign play_end  = (state_q == PLAY) && (state_d == OVER);
  // Staying in PLAY implies game_status is still 2'b10.
  assign stay_play = !entry && (state_q == PLAY);
  assign stay_over = !entry && (state_q == OVER);
  assign sec_tick  = (pcnt_q == PMAX);

  // One-second prescaler; restarts on every mode change.
  always_comb begin
    pcnt_d = pcnt_q;
    if (entry || state_q == IDLE) begin
      pcnt_d = '0;
    end else if (sec_tick) begin
      pcnt_d = '0;
    end else begin
      pcnt_d = pcnt_q + PW'(1);
    end
  end

  always_comb begin
    score_d = score_q;
    if (to_play) begin
      score_d = '0;
    end else if (stay_play && add_cube) begin
      if (score_q != SMAX) begin
        score_d = score_q + 8'd1;
      end
    end
  end

  always_comb begin
    pt_d = pt_q;
    if (to_play) begin
      pt_d = '0;
    end else if (stay_play && sec_tick) begin
      if (pt_q != TMAX) begin
        pt_d = pt_q + 10'd1;
      end
    end
  end

  // Record check uses the score held on the exit cycle.
  always_comb begin
    hs_d = hs_q;
    nr_d = nr_q;
    if (to_play) begin
      nr_d = 1'b0;
    end else if (play_end && (score_q > hs_q)) begin
      hs_d = score_q;
      nr_d = 1'b1;
    end
  end

  // Alternates score / high score in OVER every DISP_SEC seconds.
  always_comb begin
    dsec_d = dsec_q;
    show_d = show_q;
    if (entry) begin
      dsec_d = '0;
      show_d = 1'b0;
    end else if (stay_over && sec_tick) begin
      if (dsec_q == DMAX) begin
        dsec_d = '0;
        show_d = !show_q;
      end else begin
        dsec_d = dsec_q + DW'(1);
      end
    end
  end

  // t*1000 = t*1024 - t*16 - t*8
  assign t20     = {10'd0, pt_q};
  assign t_x1000 = (t20 << 10) - (t20 << 4) - (t20 << 3);

  always_comb begin
    data_d  = '0;
    point_d = '0;
    unique case (state_q)
      IDLE: begin
        data_d  = {12'd0, hs_q};
        point_d = 6'b000000;
      end
      PLAY: begin
        data_d  = t_x1000 + {12'd0, score_q};
        point_d = 6'b001000;
      end
      OVER: begin
        data_d  = show_q ? {12'd0, hs_q}
                         : {12'd0, score_q};
        point_d = show_q ? 6'b000001
                         : 6'b000000;
      end
      default: begin
        data_d  = '0;
        point_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pcnt_q  <= '0;
      dsec_q  <= '0;
      show_q  <= 1'b0;
      score_q <= '0;
      hs_q    <= '0;
      pt_q    <= '0;
      nr_q    <= 1'b0;
      data_q  <= '0;
      point_q <= '0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      dsec_q  <= dsec_d;
      show_q  <= show_d;
      score_q <= score_d;
      hs_q    <= hs_d;
      pt_q    <= pt_d;
      nr_q    <= nr_d;
      data_q  <= data_d;
      point_q <= point_d;
    end
  end

  assign score      = score_q;
  assign high_score = hs_q;
  assign play_time  = pt_q;
  assign new_record = nr_q;
  assign data       = data_q;
  assign point      = point_q;

endmodule
